// File: rtl/alarm_match_seq.sv
// Alarm time matcher: serial MSD-first BCD compare on a shared comparator.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_match_seq #(
  parameter int unsigned RING_TICKS   = 60,
  parameter int unsigned SNOOZE_TICKS = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cur_time,
  input  logic [15:0] alm_time,
  input  logic        alarm_on,
  input  logic        ring_ack,
  input  logic        snooze,
  output logic [3:0]  cmp_a,
  output logic [3:0]  cmp_b,
  output logic        cmp_en,
  input  logic        cmp_l,
  input  logic        cmp_e,
  input  logic        cmp_r,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        ring
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  localparam logic [7:0] RingLd = 8'(RING_TICKS);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] alm_q, alm_d;
  logic        res_q, res_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        ring_q, ring_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        set_ring;

`ifdef ALARM_SNOOZE_EN
  localparam logic [7:0] SnzLd = 8'(SNOOZE_TICKS);
  logic pend_q, pend_d;
  logic unused_cmp;
  assign unused_cmp = cmp_l ^ cmp_r;
`else
  logic unused_in;
  assign unused_in = cmp_l ^ cmp_r ^ snooze;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    alm_d   = alm_q;
    res_d   = res_q;
    cmp_en  = 1'b0;
    cmp_a   = 4'd0;
    cmp_b   = 4'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = cur_time;
          alm_d   = alm_time;
          idx_d   = 2'd3;
          state_d = CMP;
        end
      end
      CMP: begin
        cmp_en = 1'b1;
        cmp_a  = cur_q[{idx_q, 2'b00} +: 4];
        cmp_b  = alm_q[{idx_q, 2'b00} +: 4];
        if (!cmp_e) begin
          res_d   = 1'b0;
          state_d = DONE;
        end else if (idx_q == 2'd0) begin
          res_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done_d   = (state_q == DONE);
  assign match_d  = done_d ? res_q : match_q;
  // Ring only on a fresh match, so one matching minute rings once.
  assign set_ring = done_d && res_q && !match_q && alarm_on;

  always_comb begin
    ring_d = ring_q;
    cnt_d  = cnt_q;
`ifdef ALARM_SNOOZE_EN
    pend_d = pend_q;
`endif
    if (ring_ack || !alarm_on) begin
      ring_d = 1'b0;
      cnt_d  = 8'd0;
`ifdef ALARM_SNOOZE_EN
      pend_d = 1'b0;
`endif
    end
`ifdef ALARM_SNOOZE_EN
    else if (snooze && ring_q) begin
      ring_d = 1'b0;
      cnt_d  = SnzLd;
      pend_d = 1'b1;
    end
`endif
    else if (set_ring) begin
      ring_d = 1'b1;
      cnt_d  = RingLd;
`ifdef ALARM_SNOOZE_EN
      pend_d = 1'b0;
`endif
    end else if (start && ring_q) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_d == 8'd0) ring_d = 1'b0;
    end
`ifdef ALARM_SNOOZE_EN
    else if (start && pend_q) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_d == 8'd0) begin
        ring_d = 1'b1;
        cnt_d  = RingLd;
        pend_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd3;
      cur_q   <= 16'd0;
      alm_q   <= 16'd0;
      res_q   <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      ring_q  <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef ALARM_SNOOZE_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      alm_q   <= alm_d;
      res_q   <= res_d;
      done_q  <= done_d;
      match_q <= match_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
`ifdef ALARM_SNOOZE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign busy  = (state_q == CMP) || (state_q == DONE);
  assign done  = done_q;
  assign match = match_q;
  assign ring  = ring_q;

endmodule

// File: tb/tb_alarm_match_seq.sv
// Bench for alarm_match_seq: reference model plus directed scenarios.
// Snooze scenarios are active when ALARM_SNOOZE_EN is defined.
module tb_alarm_match_seq;
  localparam int RT = 2;
  localparam int ST = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SN = 1'b1;
`else
  localparam bit SN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic alarm_on = 1'b0, ring_ack = 1'b0, snooze = 1'b0;
  logic [15:0] cur_time = '0, alm_time = '0;
  logic [3:0] cmp_a, cmp_b;
  logic cmp_en, cmp_l, cmp_e, cmp_r;
  logic busy, done, match, ring;

  assign cmp_l = cmp_a > cmp_b;
  assign cmp_e = cmp_a == cmp_b;
  assign cmp_r = cmp_a < cmp_b;

  alarm_match_seq #(.RING_TICKS(RT), .SNOOZE_TICKS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cur_time(cur_time), .alm_time(alm_time),
    .alarm_on(alarm_on), .ring_ack(ring_ack), .snooze(snooze),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_en(cmp_en),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_r(cmp_r),
    .busy(busy), .done(done), .match(match), .ring(ring)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Reference model: a pass is a scheduled event, not a state machine.
  int e_cnt, m_t0, m_n, m_cnt, k;
  bit m_act, m_res, m_done, m_match, m_ring, m_pend;
  bit m_busy, m_en, fin, set;
  logic [15:0] m_cur, m_alm;
  logic [3:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt = 0; m_act = 0; m_res = 0; m_done = 0; m_match = 0;
      m_ring = 0; m_pend = 0; m_cnt = 0; m_busy = 0; m_en = 0;
      m_a = 0; m_b = 0; m_t0 = 0; m_n = 0;
    end else begin
      e_cnt++;
      fin = m_act && (e_cnt - m_t0 == m_n + 1);
      set = fin && m_res && !m_match && alarm_on;
      if (ring_ack || !alarm_on) begin
        m_ring = 0; m_pend = 0; m_cnt = 0;
      end else if (SN && snooze && m_ring) begin
        m_ring = 0; m_pend = 1; m_cnt = ST;
      end else if (set) begin
        m_ring = 1; m_pend = 0; m_cnt = RT;
      end else if (start && m_ring) begin
        m_cnt--;
        if (m_cnt == 0) m_ring = 0;
      end else if (start && m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ring = 1; m_pend = 0; m_cnt = RT;
        end
      end
      m_done = fin;
      if (fin) begin
        m_match = m_res;
        m_act = 0;
      end else if (!m_act && start) begin
        m_act = 1; m_t0 = e_cnt;
        m_cur = cur_time; m_alm = alm_time;
        m_n = 0; m_res = 1;
        for (int d = 3; d >= 0; d--) begin
          m_n++;
          if (m_cur[4*d +: 4] != m_alm[4*d +: 4]) begin
            m_res = 0;
            break;
          end
        end
      end
      k = e_cnt - m_t0;
      m_busy = m_act && (k <= m_n);
      m_en = m_act && (k < m_n);
      m_a = m_en ? m_cur[4*(3-k) +: 4] : 4'd0;
      m_b = m_en ? m_alm[4*(3-k) +: 4] : 4'd0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("match", match, m_match);
    chk("ring", ring, m_ring);
    chk("cmp_en", cmp_en, m_en);
    chk("cmp_a", cmp_a, m_a);
    chk("cmp_b", cmp_b, m_b);
  end

  task automatic pulse_start();
    @(negedge clk); #2 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_pass(input logic [15:0] c, input logic [15:0] a,
                          output int en_n, output logic [15:0] digs,
                          output int done_at, output logic r0);
    en_n = 0; digs = '0; done_at = -1; r0 = 1'b0;
    @(negedge clk); #2 cur_time = c; alm_time = a; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) r0 = cmp_r;
      if (cmp_en) begin
        digs = {digs[11:0], cmp_a};
        en_n++;
      end
      if (done && done_at < 0) done_at = j;
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk); #2;
    if (which == 0) ring_ack = 1'b1; else snooze = 1'b1;
    @(posedge clk); #1 ring_ack = 1'b0; snooze = 1'b0;
    @(negedge clk);
  endtask

  int en_n, done_at, dn;
  logic [15:0] digs, rc, ra;
  logic r0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ring", ring, 0);
    chk("rst_cmp_en", cmp_en, 0);
    #2 rst_n = 1'b1; alarm_on = 1'b1;

    run_pass(16'h0730, 16'h0730, en_n, digs, done_at, r0);
    chk("m4_en_cycles", en_n, 4);
    chk("m4_digits", digs, 16'h0730);
    chk("m4_done_at", done_at, 5);
    chk("m4_match", match, 1);
    chk("m4_ring", ring, 1);

    pulse(0);
    chk("ack_ring", ring, 0);

    run_pass(16'h0731, 16'h1731, en_n, digs, done_at, r0);
    chk("mis_en_cycles", en_n, 1);
    chk("mis_cmp_r", r0, 1);
    chk("mis_done_at", done_at, 2);
    chk("mis_match", match, 0);
    chk("mis_ring", ring, 0);

    run_pass(16'h1200, 16'h1200, en_n, digs, done_at, r0);
    chk("tick1_ring", ring, 1);
    run_pass(16'h1200, 16'h1200, en_n, digs, done_at, r0);
    chk("tick2_ring", ring, 1);
    run_pass(16'h1200, 16'h1200, en_n, digs, done_at, r0);
    chk("tick3_ring", ring, 0);
    chk("tick3_match", match, 1);

    pulse_start();
    dn = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (done) dn++;
      if (j == 1) begin
        #2 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    chk("busy_single_done", dn, 1);

    @(negedge clk); #2 cur_time = 16'h1234; alm_time = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_digit_idx2", cmp_a, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_match", match, 0);
    chk("arst_cmp", {cmp_en, cmp_a, cmp_b}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    dn = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("arst_no_done", dn, 0);

    run_pass(16'h2359, 16'h2359, en_n, digs, done_at, r0);
    chk("snz_ring_on", ring, 1);
    pulse(1);
`ifdef ALARM_SNOOZE_EN
    chk("snz_ring_off", ring, 0);
    run_pass(16'h2359, 16'h2359, en_n, digs, done_at, r0);
    chk("snz_tick1", ring, 0);
    run_pass(16'h2359, 16'h2359, en_n, digs, done_at, r0);
    chk("snz_tick2", ring, 0);
    run_pass(16'h2359, 16'h2359, en_n, digs, done_at, r0);
    chk("snz_tick3", ring, 1);
`else
    chk("snz_ignored", ring, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      if ($urandom_range(3) == 0) begin
        ra = 16'($urandom);
        rc = ra;
        if ($urandom_range(1) == 0)
          rc = ra ^ (16'h1 << (4 * $urandom_range(3)));
        cur_time = rc;
        alm_time = ra;
      end
      start = ($urandom_range(5) == 0);
      ring_ack = ($urandom_range(39) == 0);
      snooze = ($urandom_range(14) == 0);
      alarm_on = ($urandom_range(49) != 0);
    end
    @(negedge clk); #2 start = 0; ring_ack = 0; snooze = 0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/alarm_match_seq.md
ALARM_MATCH_SEQ -- requirements
Module: alarm_match_seq

Interface
REQ-001 SHALL have parameter RING_TICKS, default 60, meaning ring duration in start ticks (1..255).
REQ-002 SHALL have parameter SNOOZE_TICKS, default 120, meaning snooze delay in start ticks (1..255).
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle tick (1 Hz strobe) requesting a compare pass.
REQ-006 SHALL have port cur_time  input  16  current BCD digits {H10,H1,M10,M1}, [15:12]=H10.
REQ-007 SHALL have port alm_time  input  16  alarm BCD digits, same packing.
REQ-008 SHALL have port alarm_on  input  1  alarm enable switch.
REQ-009 SHALL have port ring_ack  input  1  one-cycle stop request.
REQ-010 SHALL have port snooze  input  1  one-cycle snooze request (used only with ALARM_SNOOZE_EN).
REQ-011 SHALL have ports cmp_a/cmp_b  output  4 each  digit operands to the shared 4-bit comparator.
REQ-012 SHALL have port cmp_en  output  1  comparator enable.
REQ-013 SHALL have ports cmp_l/cmp_e/cmp_r  input  1 each  comparator A>B / A==B / A<B results (combinational, same cycle).
REQ-014 SHALL have ports busy, done, match, ring  output  1 each  pass in progress / one-cycle pass-complete pulse / last pass result / alarm sounding.

Function
REQ-015 FSM states SHALL be IDLE, CMP, DONE; IDLE->CMP on start, CMP->DONE on mismatch or last digit, DONE->IDLE unconditionally.
REQ-016 On start in IDLE, SHALL snapshot cur_time and alm_time, set digit index to 3 (H10, MSD first).
REQ-017 In CMP, SHALL drive cmp_a=snapshot cur digit[idx], cmp_b=alm digit[idx], cmp_en=1; outside CMP cmp_en=0 and cmp_a=cmp_b=0.
REQ-018 In CMP, cmp_e=0 SHALL end the pass (match result 0); cmp_e=1 with idx=0 SHALL end it with match result 1; otherwise idx decrements.
REQ-019 Latency: done SHALL pulse exactly N+1 cycles after the start edge, N = digits compared (1..4); match updates in the same cycle as done and holds until next done.
REQ-020 busy SHALL be 1 in CMP and DONE, else 0; start while busy SHALL be ignored.
REQ-021 cmp_l/cmp_r SHALL NOT affect behaviour (cmp_e alone decides); all three checked one-hot in verification.
REQ-022 ring SHALL set at done only on a 0->1 transition of match with alarm_on=1 (no re-trigger for the rest of the matching minute).
REQ-023 While ring=1, an 8-bit counter loaded with RING_TICKS SHALL decrement on each start; ring clears when it reaches 0.
REQ-024 ring_ack or alarm_on=0 SHALL clear ring next cycle; ring_ack coinciding with a ring-setting done SHALL win (ring stays 0).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, idx=3, busy=0, done=0, match=0, ring=0, counters=0, cmp_en=0, cmp_a=cmp_b=0, snooze pending=0, previous-match flag=0.
REQ-026 Reset mid-pass SHALL abort the pass with no done pulse; first pass after release requires a new start.

Configuration
REQ-027 With ALARM_SNOOZE_EN defined: snooze while ring=1 SHALL clear ring, load counter with SNOOZE_TICKS, set pending; each start decrements; at 0 ring re-sets with RING_TICKS; ring_ack or alarm_on=0 clears pending.
REQ-028 Without ALARM_SNOOZE_EN: snooze input SHALL be ignored and no pending state exists.

Verification
REQ-029 cur=alm=16'h0730, alarm_on=1, start -> cmp_en high 4 cycles (digits 0,7,3,0), done at +5, match=1, ring=1.
REQ-030 cur=16'h0731, alm=16'h1731 -> one CMP cycle (0 vs 1, cmp_r=1), done at +2, match=0, ring=0.
REQ-031 Matching time, 3 successive starts -> ring set once; RING_TICKS=2 -> ring clears after 2nd later start, no re-trigger.
REQ-032 Ringing, ring_ack pulse -> ring=0 next cycle; start during busy -> ignored, single done.
REQ-033 rst_n low during CMP at idx=2 -> all outputs 0 immediately, no done; ALARM_SNOOZE_EN, SNOOZE_TICKS=3, snooze while ringing -> ring=0, re-rings after 3 starts.
